// File: rtl/lcd_pkg.sv
// Shared constants, state types and ASCII helpers for the 2x16 character-LCD word writer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;

  localparam logic [5:0] LINE_CHARS = 6'd16;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR,
    ST_WRAP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_EN,
    WR_HOLD
  } wr_phase_e;

  function automatic logic [7:0] ascii_nibble(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte onto the LCD bus: a setup clock, an enable pulse, then a settle/hold window.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned CLEAR_CYCLES  = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_byte,
  input  logic       rs,
  input  logic       long_settle,
  output logic       done,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       lcd_rs
);

  localparam int unsigned CNT_TOP = (EN_CYCLES > CLEAR_CYCLES) ? EN_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] EN_LOAD     = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD  = CW'(CLEAR_CYCLES - 1);

  wr_phase_e       phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            long_q, long_d;
  logic            en_q, en_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    done    = (phase_q == WR_HOLD) && (cnt_q == '0);

    case (phase_q)
      WR_SETUP: begin
        phase_d = WR_EN;
        cnt_d   = EN_LOAD;
      end
      WR_EN: begin
        if (cnt_q == '0) begin
          phase_d = WR_HOLD;
          cnt_d   = long_q ? CLEAR_LOAD : SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: begin
        if (cnt_q == '0) phase_d = WR_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    // A new byte may be taken on the final hold clock so consecutive bytes run gap-free.
    if (start && ((phase_q == WR_IDLE) || done)) begin
      phase_d = WR_SETUP;
      data_d  = data_byte;
      rs_d    = rs;
      long_d  = long_settle;
    end

    en_d = (phase_d == WR_EN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= WR_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  assign lcd_en   = en_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;

endmodule

// File: rtl/lcd_word_display.sv
// Renders a DATA_W-bit word as binary or hex text on a 2x16 LCD, with power-on init and line wrap.
module lcd_word_display
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_W        = 18,
  parameter int unsigned EN_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned CLEAR_CYCLES  = 1600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_hex,
  input  logic              wr_line,
  output logic              busy,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en
);

  localparam logic [5:0] NCHAR_BIN = 6'(DATA_W);
  localparam logic [5:0] NCHAR_HEX = 6'((DATA_W + 3) / 4);

  state_e            state_q, state_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic [5:0]        idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic              line_q, line_d;
  logic              hex_q, hex_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic        wr_start, wr_done, wr_rs, wr_long;
  logic [7:0]  wr_byte;
  logic [5:0]  nchar;
  logic [4:0]  pos;
  logic [31:0] word_ext;

  assign nchar    = hex_q ? NCHAR_HEX : NCHAR_BIN;
  assign word_ext = 32'(word_q);

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    idx_d      = idx_q;
    wrap_d     = wrap_q;
    line_d     = line_q;
    hex_d      = hex_q;
    word_d     = word_q;

    case (state_q)
      ST_INIT: begin
        if (wr_done) begin
          if (init_idx_q == 2'd3) state_d    = ST_IDLE;
          else                    init_idx_d = init_idx_q + 2'd1;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (wr_valid) begin
          word_d  = wr_data;
          hex_d   = wr_hex;
          line_d  = wr_line;
          idx_d   = '0;
          wrap_d  = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (wr_done) state_d = ST_CHAR;
      end
      ST_CHAR: begin
        if (wr_done) begin
          idx_d = idx_q + 6'd1;
          if (idx_d == nchar)                         state_d = ST_DONE;
          else if ((idx_d == LINE_CHARS) && !wrap_q)  state_d = ST_WRAP;
        end
      end
      ST_WRAP: begin
        if (wr_done) begin
          wrap_d  = 1'b1;
          state_d = ST_CHAR;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // The next byte is built from the next-state values so the writer can chain it on its done clock.
  always_comb begin
    pos      = 5'(nchar - 6'd1 - idx_d);
    wr_rs    = 1'b0;
    wr_long  = 1'b0;
    wr_byte  = '0;
    wr_start = (state_q inside {ST_INIT, ST_ADDR, ST_CHAR, ST_WRAP}) &&
               (state_d inside {ST_INIT, ST_ADDR, ST_CHAR, ST_WRAP});
    case (state_d)
      ST_INIT: begin
        wr_byte = init_cmd(init_idx_d);
        wr_long = (init_idx_d == 2'd3);
      end
      ST_ADDR: wr_byte = line_q ? CMD_LINE1 : CMD_LINE0;
      ST_WRAP: wr_byte = line_q ? CMD_LINE0 : CMD_LINE1;
      ST_CHAR: begin
        wr_rs = 1'b1;
        if (hex_q) wr_byte = ascii_nibble(4'(word_ext >> {pos[2:0], 2'b00}));
        else       wr_byte = 8'h30 + {7'd0, word_ext[pos]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      idx_q      <= '0;
      wrap_q     <= 1'b0;
      line_q     <= 1'b0;
      hex_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      idx_q      <= idx_d;
      wrap_q     <= wrap_d;
      line_q     <= line_d;
      hex_q      <= hex_d;
      word_q     <= word_d;
    end
  end

  lcd_byte_writer #(
    .EN_CYCLES    (EN_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .start      (wr_start),
    .data_byte  (wr_byte),
    .rs         (wr_rs),
    .long_settle(wr_long),
    .done       (wr_done),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs)
  );

  assign wr_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy     = ~wr_ready;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_word_display.sv
// Randomized self-checking bench: captured LCD bytes and latencies are compared to a text-level model.
module tb_lcd_word_display;

  localparam int EN = 2;
  localparam int ST = 4;
  localparam int CL = 10;
  localparam int P  = 1 + EN + ST;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v18 = 1'b0, h18 = 1'b0, l18 = 1'b0;
  logic [17:0] d18 = '0;
  logic        r18, b18, rs18, rw18, en18;
  logic [7:0]  ld18;
  logic        v32 = 1'b0, h32 = 1'b0, l32 = 1'b0;
  logic [31:0] d32 = '0;
  logic        r32, b32, rs32, rw32, en32;
  logic [7:0]  ld32;

  lcd_word_display #(.DATA_W(18), .EN_CYCLES(EN), .SETTLE_CYCLES(ST), .CLEAR_CYCLES(CL)) dut18 (
    .clk(clk), .rst(rst), .wr_valid(v18), .wr_ready(r18), .wr_data(d18), .wr_hex(h18),
    .wr_line(l18), .busy(b18), .lcd_data(ld18), .lcd_rs(rs18), .lcd_rw(rw18), .lcd_en(en18));

  lcd_word_display #(.DATA_W(32), .EN_CYCLES(EN), .SETTLE_CYCLES(ST), .CLEAR_CYCLES(CL)) dut32 (
    .clk(clk), .rst(rst), .wr_valid(v32), .wr_ready(r32), .wr_data(d32), .wr_hex(h32),
    .wr_line(l32), .busy(b32), .lcd_data(ld32), .lcd_rs(rs32), .lcd_rw(rw32), .lcd_en(en32));

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: one entry {rs,data} per enable pulse, plus pulse width and data stability.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       pen[2];
  int         elen[2];
  logic [8:0] lat[2];
  logic [8:0] pd[2];

  task automatic mon(input int k, input logic en, input logic rs, input logic [7:0] d, input logic rw);
    if (rst) begin
      pen[k] = 1'b0;
      pd[k]  = {rs, d};
      return;
    end
    if (en && !pen[k]) begin
      if (k == 0) q0.push_back({rs, d}); else q1.push_back({rs, d});
      check("setup_stable", {23'd0, pd[k]}, {23'd0, rs, d});
      check("rw_low", {31'd0, rw}, 32'd0);
      elen[k] = 1;
      lat[k]  = {rs, d};
    end else if (en) begin
      elen[k]++;
    end else if (pen[k]) begin
      check("en_width", elen[k], EN);
      check("hold_stable", {23'd0, rs, d}, {23'd0, lat[k]});
    end
    pen[k] = en;
    pd[k]  = {rs, d};
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, en18, rs18, ld18, rw18);
    mon(1, en32, rs32, ld32, rw32);
  end

  // Reference: the text the word should produce, then the byte stream with address and wrap commands.
  logic [8:0] expq[$];

  function automatic int build(input int dw, input logic [31:0] w, input bit hx, input bit ln);
    string      hs = "0123456789ABCDEF";
    logic [7:0] chars[$];
    if (hx) begin
      for (int i = (dw + 3) / 4 - 1; i >= 0; i--) chars.push_back(hs[int'((w >> (4 * i)) & 32'hF)]);
    end else begin
      for (int i = dw - 1; i >= 0; i--) chars.push_back(w[i] ? 8'h31 : 8'h30);
    end
    expq.delete();
    expq.push_back({1'b0, ln ? 8'hC0 : 8'h80});
    foreach (chars[j]) begin
      if (j == 16) expq.push_back({1'b0, ln ? 8'h80 : 8'hC0});
      expq.push_back({1'b1, chars[j]});
    end
    return expq.size();
  endfunction

  task automatic run_txn(input int k, input logic [31:0] w, input bit hx, input bit ln,
                         input bit poke, input string tag);
    int          dw  = (k == 0) ? 18 : 32;
    logic [31:0] wm  = (k == 0) ? (w & 32'h3FFFF) : w;
    int          nb;
    int          cyc = 0;
    logic [8:0]  got[$];
    nb = build(dw, wm, hx, ln);
    while (!((k == 0) ? r18 : r32) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (k == 0) begin v18 = 1'b1; d18 = wm[17:0]; h18 = hx; l18 = ln; q0.delete(); end
    else        begin v32 = 1'b1; d32 = wm;       h32 = hx; l32 = ln; q1.delete(); end
    @(negedge clk);
    v18 = 1'b0; v32 = 1'b0;
    d18 = 18'($urandom); d32 = $urandom; h18 = ~hx; h32 = ~hx; l18 = ~ln; l32 = ~ln;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if ((k == 0) ? r18 : r32) break;
      if (poke && cyc == 30) begin
        if (k == 0) begin v18 = 1'b1; d18 = ~wm[17:0]; end
        else        begin v32 = 1'b1; d32 = ~wm;       end
      end else begin
        v18 = 1'b0; v32 = 1'b0;
      end
    end
    v18 = 1'b0; v32 = 1'b0;
    if (k == 0) got = q0; else got = q1;
    check({tag, "_latency"}, cyc, nb * P + 1);
    check({tag, "_nbytes"}, got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {23'd0, got[i]}, {23'd0, expq[i]});
  endtask

  task automatic init_check(input string tag);
    int         cyc = 0;
    logic [8:0] init_exp[4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
    q0.delete(); q1.delete();
    rst = 1'b0;
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (r18) break;
    end
    check({tag, "_latency"}, cyc, 35);
    check({tag, "_ready32"}, {31'd0, r32}, 32'd1);
    check({tag, "_nbytes"}, q0.size(), 4);
    for (int i = 0; i < 4 && i < q0.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), {23'd0, q0[i]}, {23'd0, init_exp[i]});
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, ld18}, 32'h00);
    check("rst_rs", {31'd0, rs18}, 32'd0);
    check("rst_rw", {31'd0, rw18}, 32'd0);
    check("rst_en", {31'd0, en18}, 32'd0);
    check("rst_ready", {31'd0, r18}, 32'd0);
    check("rst_busy", {31'd0, b18}, 32'd1);

    init_check("init");
    check("idle_busy", {31'd0, b18}, 32'd0);

    run_txn(0, 32'h2A5A5, 1'b0, 1'b0, 1'b0, "bin18");
    check("bin18_count", q0.size(), 20);
    run_txn(0, 32'h3FFFF, 1'b1, 1'b1, 1'b0, "hex18");
    run_txn(1, $urandom, 1'b0, 1'b1, 1'b0, "bin32");
    check("bin32_count", q1.size(), 34);
    run_txn(1, $urandom, 1'b1, 1'b0, 1'b0, "hex32");

    for (int t = 0; t < 8; t++) begin
      run_txn(t % 2, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
              $sformatf("rnd%0d", t));
    end
    run_txn(0, $urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b1, "poke18");
    run_txn(1, $urandom, 1'b1, 1'($urandom_range(0, 1)), 1'b1, "poke32");

    // Abort a transaction while a character enable pulse is high.
    @(negedge clk);
    v18 = 1'b1; d18 = 18'($urandom); h18 = 1'b0; l18 = 1'b0;
    @(negedge clk);
    v18 = 1'b0;
    cyc = 0;
    while (!(en18 && rs18) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_char", {31'd0, en18 && rs18}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_en", {31'd0, en18}, 32'd0);
    check("abort_data", {24'd0, ld18}, 32'h00);
    check("abort_ready", {31'd0, r18}, 32'd0);
    check("abort_busy", {31'd0, b18}, 32'd1);
    init_check("reinit");
    run_txn(0, $urandom, 1'b1, 1'b0, 1'b0, "post_abort");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
